// File: rtl/anim_pkg.sv
// Shared types for the bouncing-sprite animation engine: FSM state codes,
// per-object record and the single-axis edge-bounce step.
package anim_pkg;

    localparam int POS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ERASE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_DRAW  = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] pos_x;
        logic [POS_W-1:0] pos_y;
        logic             dir_x;
        logic             dir_y;
    } obj_t;

    // Returns {dir, pos} after one step; hi is the largest legal top-left coordinate.
    function automatic logic [POS_W:0] bounce_step(input logic [POS_W-1:0] pos,
                                                   input logic             dir,
                                                   input logic [POS_W-1:0] hi);
        logic [POS_W:0] r;
        if (dir && pos == hi)
            r = {1'b0, pos - POS_W'(1)};
        else if (!dir && pos == '0)
            r = {1'b1, POS_W'(1)};
        else if (dir)
            r = {1'b1, pos + POS_W'(1)};
        else
            r = {1'b0, pos - POS_W'(1)};
        return r;
    endfunction

endpackage

// File: rtl/anim_box_scan.sv
// Raster counter walking px/py over a BOX x BOX sprite, one pixel per advance.
module anim_box_scan #(
    parameter int W   = 8,
    parameter int BOX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         adv,
    output logic [W-1:0] px,
    output logic [W-1:0] py,
    output logic         last
);

    localparam logic [W-1:0] EDGE = W'(BOX - 1);

    assign last = (px == EDGE) && (py == EDGE);

    // Counter wraps back to (0,0) after the last pixel, so back-to-back scans need no clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px <= '0;
            py <= '0;
        end else if (start) begin
            px <= '0;
            py <= '0;
        end else if (adv) begin
            if (px == EDGE) begin
                px <= '0;
                py <= (py == EDGE) ? '0 : py + W'(1);
            end else begin
                px <= px + W'(1);
            end
        end
    end

endmodule

// File: rtl/bounce_anim_engine.sv
// N-object bouncing square animator: per frame erases, moves and redraws each
// sprite through the pixel-plot interface, one pixel per clock.
module bounce_anim_engine
    import anim_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int COLOR_W   = 3,
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120,
    parameter int BOX       = 4,
    parameter int NOBJ      = 2,
    parameter int FRAME_CYC = 833333,
    parameter int BG_COLOR  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color_draw,
    output logic               plot,
    output logic               frame_done,
    output logic               busy,
    output logic [2:0]         state
);

    localparam int TMR_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int OBJ_W = (NOBJ > 1) ? $clog2(NOBJ) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FRAME_CYC - 1);
    localparam logic [OBJ_W-1:0] OBJ_LAST = OBJ_W'(NOBJ - 1);

    function automatic obj_t obj_init(input int i);
        obj_t o;
        o.pos_x = POS_W'((2 * BOX * i) % (SCR_W - BOX + 1));
        o.pos_y = POS_W'((BOX * i) % (SCR_H - BOX + 1));
        o.dir_x = 1'b1;
        o.dir_y = 1'b1;
        return o;
    endfunction

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [OBJ_W-1:0]   obj_q, obj_d;
    obj_t               objs [NOBJ];
    obj_t               sel;
    logic [POS_W:0]     nx, ny;
    logic [COORD_W-1:0] px, py;
    logic               scan_last, scan_clr, scan_adv, move_en, fdone_d;

    anim_box_scan #(.W(COORD_W), .BOX(BOX)) u_scan (
        .clk   (clk),
        .reset (reset),
        .start (scan_clr),
        .adv   (scan_adv),
        .px    (px),
        .py    (py),
        .last  (scan_last)
    );

    assign sel   = objs[obj_q];
    assign nx    = bounce_step(sel.pos_x, sel.dir_x, POS_W'(SCR_W - BOX));
    assign ny    = bounce_step(sel.pos_y, sel.dir_y, POS_W'(SCR_H - BOX));
    assign state = state_q;
    assign busy  = (state_q == ST_ERASE) || (state_q == ST_MOVE) ||
                   (state_q == ST_DRAW)  || (state_q == ST_NEXT);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        obj_d    = obj_q;
        scan_clr = 1'b0;
        scan_adv = 1'b0;
        move_en  = 1'b0;
        fdone_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                    timer_d = TMR_LOAD;
                end
            end
            // A low enable freezes the frame timer rather than restarting it.
            ST_WAIT: begin
                if (enable) begin
                    if (timer_q == '0) begin
                        state_d  = ST_ERASE;
                        obj_d    = '0;
                        scan_clr = 1'b1;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            ST_ERASE: begin
                scan_adv = 1'b1;
                if (scan_last) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                move_en  = 1'b1;
                scan_clr = 1'b1;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                scan_adv = 1'b1;
                if (scan_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (obj_q < OBJ_LAST) begin
                    obj_d    = obj_q + OBJ_W'(1);
                    state_d  = ST_ERASE;
                    scan_clr = 1'b1;
                end else begin
                    obj_d   = '0;
                    fdone_d = 1'b1;
                    state_d = ST_WAIT;
                    timer_d = TMR_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= TMR_LOAD;
            obj_q   <= '0;
            for (int i = 0; i < NOBJ; i++) objs[i] <= obj_init(i);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            obj_q   <= obj_d;
            if (move_en) begin
                objs[obj_q].pos_x <= nx[POS_W-1:0];
                objs[obj_q].dir_x <= nx[POS_W];
                objs[obj_q].pos_y <= ny[POS_W-1:0];
                objs[obj_q].dir_y <= ny[POS_W];
            end
        end
    end

    // Pixel outputs lag the scan state by one register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            color_draw <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            x          <= COORD_W'(sel.pos_x + POS_W'(px));
            y          <= COORD_W'(sel.pos_y + POS_W'(py));
            color_draw <= (state_q == ST_DRAW) ? COLOR_W'(int'(obj_q) + 1)
                                               : COLOR_W'(BG_COLOR);
            plot       <= (state_q == ST_ERASE) || (state_q == ST_DRAW);
            frame_done <= fdone_d;
        end
    end

endmodule

// File: tb/tb_bounce_anim_engine.sv
// Directed bench: default config (A), tiny screen edge/corner bounce (B),
// frame period with three small objects (C).
module tb_bounce_anim_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // DUT A: defaults with a short frame wait
    logic       a_rst, a_en, a_plot, a_fd, a_busy;
    logic [7:0] a_x, a_y;
    logic [2:0] a_col, a_st;
    bounce_anim_engine #(.FRAME_CYC(4)) dut_a (
        .clk(clk), .reset(a_rst), .enable(a_en), .x(a_x), .y(a_y),
        .color_draw(a_col), .plot(a_plot), .frame_done(a_fd), .busy(a_busy), .state(a_st)
    );

    // DUT B: 8x8 screen, one 4x4 object
    logic       b_rst, b_en, b_plot, b_fd, b_busy;
    logic [7:0] b_x, b_y;
    logic [2:0] b_col, b_st;
    bounce_anim_engine #(.SCR_W(8), .SCR_H(8), .BOX(4), .NOBJ(1), .FRAME_CYC(2)) dut_b (
        .clk(clk), .reset(b_rst), .enable(b_en), .x(b_x), .y(b_y),
        .color_draw(b_col), .plot(b_plot), .frame_done(b_fd), .busy(b_busy), .state(b_st)
    );

    // DUT C: frame period measurement
    logic       c_rst, c_en, c_plot, c_fd, c_busy;
    logic [7:0] c_x, c_y;
    logic [2:0] c_col, c_st;
    bounce_anim_engine #(.FRAME_CYC(10), .BOX(2), .NOBJ(3)) dut_c (
        .clk(clk), .reset(c_rst), .enable(c_en), .x(c_x), .y(c_y),
        .color_draw(c_col), .plot(c_plot), .frame_done(c_fd), .busy(c_busy), .state(c_st)
    );

    int exp_pos [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};

    initial begin
        int n;
        int found;
        int bad;
        a_rst = 1'b0; a_en = 1'b0;
        b_rst = 1'b0; b_en = 1'b0;
        c_rst = 1'b0; c_en = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_state", a_st, 0);
        check("rst_plot", a_plot, 0);
        check("rst_frame_done", a_fd, 0);
        check("rst_busy", a_busy, 0);
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_color", a_col, 0);

        // ---- A: first frame ----
        a_rst = 1'b1; a_en = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk); n++;
            if (a_plot) found = 1;
        end
        check("first_plot_found", found, 1);
        check("first_plot_latency", n, 6);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            check("obj0_erase_plot", a_plot, 1);
            check("obj0_erase_x", a_x, k % 4);
            check("obj0_erase_y", a_y, k / 4);
            check("obj0_erase_color", a_col, 0);
        end
        @(negedge clk);
        check("move_gap_plot", a_plot, 0);
        check("move_gap_state", a_st, 4);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("obj0_draw_plot", a_plot, 1);
            check("obj0_draw_x", a_x, 1 + k % 4);
            check("obj0_draw_y", a_y, 1 + k / 4);
            check("obj0_draw_color", a_col, 1);
        end
        @(negedge clk);
        check("next_gap_plot", a_plot, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) check("obj1_erase_state", a_st, 2);
            check("obj1_erase_plot", a_plot, 1);
            check("obj1_erase_x", a_x, 8 + k % 4);
            check("obj1_erase_y", a_y, 4 + k / 4);
            check("obj1_erase_color", a_col, 0);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("obj1_draw_x", a_x, 9 + k % 4);
            check("obj1_draw_y", a_y, 5 + k / 4);
            check("obj1_draw_color", a_col, 2);
        end
        @(negedge clk);
        check("frame_done_pulse", a_fd, 1);
        check("frame_done_plot", a_plot, 0);
        check("frame_done_state", a_st, 1);
        check("frame_done_busy", a_busy, 0);
        @(negedge clk);
        check("frame_done_width", a_fd, 0);

        // ---- A: enable drop during DRAW of obj0 ----
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (a_plot && a_col == 3'd1) found = 1;
        end
        check("frame2_draw_found", found, 1);
        check("frame2_draw_x", a_x, 2);
        check("frame2_draw_y", a_y, 2);
        a_en = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (a_fd) found = 1;
        end
        check("disable_frame_done", found, 1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_plot || a_st != 3'd1) bad++;
        end
        check("disable_hold_wait", bad, 0);

        // ---- A: reset mid-ERASE ----
        a_en = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (a_plot) found = 1;
        end
        check("resume_erase_found", found, 1);
        check("resume_erase_state", a_st, 2);
        a_rst = 1'b0;
        #1;
        check("async_rst_state", a_st, 0);
        check("async_rst_plot", a_plot, 0);
        check("async_rst_busy", a_busy, 0);
        @(negedge clk);
        a_rst = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (a_plot) found = 1;
        end
        check("post_rst_plot_found", found, 1);
        check("post_rst_erase_x", a_x, 0);
        check("post_rst_erase_y", a_y, 0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (a_plot && a_col == 3'd1) found = 1;
        end
        check("post_rst_draw_found", found, 1);
        check("post_rst_draw_x", a_x, 1);
        check("post_rst_draw_y", a_y, 1);
        a_en = 1'b0;

        // ---- B: edge and corner bounce over ten frames ----
        b_rst = 1'b1; b_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            found = 0;
            for (int i = 0; i < 100 && found == 0; i++) begin
                @(negedge clk);
                if (b_plot && b_col == 3'd1) found = 1;
            end
            check("b_draw_found", found, 1);
            check("b_draw_x", b_x, exp_pos[f]);
            check("b_draw_y", b_y, exp_pos[f]);
            repeat (15) @(negedge clk);
            check("b_draw_last_x", b_x, exp_pos[f] + 3);
            check("b_draw_last_y", b_y, exp_pos[f] + 3);
        end
        b_en = 1'b0;

        // ---- C: frame_done spacing and width ----
        c_rst = 1'b1; c_en = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (c_fd) found = 1;
        end
        check("c_first_done_found", found, 1);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check("c_done_width", c_fd, 0);
            n = 1; found = 0;
            for (int i = 0; i < 100 && found == 0; i++) begin
                @(negedge clk); n++;
                if (c_fd) found = 1;
            end
            check("c_done_found", found, 1);
            check("c_frame_period", n, 40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bounce_anim_engine.md
# bounce_anim_engine

Parametrised multi-object animation engine driving the VGA pixel-plot interface (x, y, color, plot). Each frame it erases every object's square sprite, advances it one pixel along its velocity with edge bounce, and redraws it, one pixel per cycle. It is the generalised successor to the single-object controller/datapath pair, adding N objects, configurable sprite size, coordinate and color widths, and edge reflection.

## Interface
Parameters:
- COORD_W, 8, width of x/y outputs and position registers
- COLOR_W, 3, color width
- SCR_W, 160, screen width in pixels (≤ 2^COORD_W)
- SCR_H, 120, screen height in pixels (≤ 2^COORD_W)
- BOX, 4, sprite side length (≥ 1; 2·BOX ≤ SCR_W and SCR_H)
- NOBJ, 2, object count (1..8)
- FRAME_CYC, 833333, cycles spent in WAIT per frame (≥ 1)
- BG_COLOR, 0, erase color

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  frames start only while high
- x  out  COORD_W  pixel x
- y  out  COORD_W  pixel y
- color_draw  out  COLOR_W  pixel color
- plot  out  1  pixel write strobe; x/y/color valid when high
- frame_done  out  1  one-cycle pulse after the last object is drawn
- busy  out  1  high in ERASE/MOVE/DRAW/NEXT
- state  out  3  current FSM state code, debug

## Operation
- Per object i: pos_x, pos_y (COORD_W), dir_x, dir_y (1 bit, 1 = +1), color = (i+1) mod 2^COLOR_W, constant.
- Reset values: pos_x = 2·BOX·i mod (SCR_W−BOX+1), pos_y = BOX·i mod (SCR_H−BOX+1), dir_x = dir_y = 1; state IDLE; timer = FRAME_CYC−1; obj index, px, py = 0; all outputs 0.
- States/codes: IDLE 0, WAIT 1, ERASE 2, MOVE 3, DRAW 4, NEXT 5.
- IDLE: enable=1 → WAIT (timer loaded FRAME_CYC−1).
- WAIT: timer decrements each cycle; at 0 → ERASE with obj=0, px=py=0. enable=0 in WAIT freezes timer; stays in WAIT.
- ERASE: plot=1, x=pos_x+px, y=pos_y+py, color=BG_COLOR. px increments; px wraps at BOX−1 with py increment; after (BOX−1,BOX−1) → MOVE.
- MOVE (1 cycle, plot=0), per axis independently: dir=1 and pos = LIMIT−BOX → dir←0, pos←pos−1; dir=0 and pos=0 → dir←1, pos←1; else pos±1. LIMIT = SCR_W (x) / SCR_H (y). Then → DRAW, px=py=0.
- DRAW: as ERASE but color = object color; after last pixel → NEXT.
- NEXT (1 cycle): obj<NOBJ−1 → obj+1, ERASE. Else obj←0, frame_done=1, → WAIT with timer reloaded.
- enable deasserted mid-frame: current frame completes; engine then holds in WAIT.
- Coordinates never exceed SCR_W−1 / SCR_H−1; no modular wrap occurs.
- reset asserted mid-frame: immediate return to reset values; partially drawn pixels are not repaired.

## Timing
- Outputs x, y, color_draw, plot, frame_done registered; change on clk rising edge only.
- Per object: BOX² erase + 1 MOVE + BOX² draw + 1 NEXT cycles.
- Frame period with enable held: FRAME_CYC + NOBJ·(2·BOX² + 2) cycles.
- First plot: FRAME_CYC + 1 cycles after first enable-high sample in IDLE, plus 1 register stage.
- frame_done coincides with WAIT entry; plot is 0 that cycle.

## Structure
- Package anim_pkg: state enum and codes, object-record typedef (pos_x, pos_y, dir_x, dir_y).
- One sub-module, anim_box_scan: px/py raster counter over BOX×BOX with start/last outputs, used by ERASE and DRAW.
- Object registers held in an NOBJ array, selected by obj index; bounce logic combinational on the selected entry.

## Test plan
- Defaults, FRAME_CYC=4: release reset, enable=1 → first plot at x=0,y=0,color=0; 16 erase pixels; then 16 draws starting (1,1), color 1; then obj1 erase at (8,4).
- Right edge: SCR_W=8, BOX=4, NOBJ=1, obj at x=4, dir_x=1 → after MOVE pos_x=3, dir_x=0; next frame pos_x=2.
- Corner bounce at (0,0) moving −1,−1 → pos (1,1), both dirs +1.
- Frame period: FRAME_CYC=10, BOX=2, NOBJ=3 → frame_done pulses exactly 40 cycles apart, one cycle wide.
- enable drop during DRAW of obj0 → frame finishes, frame_done pulses, state stays 1, no further plot.
- reset low mid-ERASE → within the same cycle state=0, plot=0, positions back to reset values.
